// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared encodings for the nibble-serial add/subtract sequencer.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/cla_seq_alu_ctrl_cla4.sv
`default_nettype none
// ============================================================================
// Module   : cla_seq_alu_ctrl_cla4
// Brief    : 4-bit augmented carry-lookahead slice (sum plus block P/G).
// Revision : 1.0
// ============================================================================
module cla_seq_alu_ctrl_cla4
    import alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] in1,
    input  logic [NIBBLE_W-1:0] in2,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] sum,
    output logic                p,
    output logic                g
);

    logic [NIBBLE_W-1:0] w_p;
    logic [NIBBLE_W-1:0] w_g;
    logic [NIBBLE_W-1:0] w_c;

    assign w_p = in1 ^ in2;
    assign w_g = in1 & in2;

    // Internal carries in flattened lookahead form rather than rippled.
    assign w_c[0] = c_in;
    assign w_c[1] = w_g[0] | (w_p[0] & c_in);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & c_in);

    assign sum = w_p ^ w_c;
    assign p   = &w_p;
    assign g   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule : cla_seq_alu_ctrl_cla4
`default_nettype wire

// File: rtl/cla_seq_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cla_seq_alu_ctrl
// Brief    : Nibble-serial add/subtract unit sharing one 4-bit CLA slice.
// Revision : 1.0
// ============================================================================
module cla_seq_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t                    r_state;
    logic [WIDTH-1:0]          r_a;
    logic [WIDTH-1:0]          r_b;
    logic [WIDTH-NIBBLE_W-1:0] r_sh;
    logic                      r_carry;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_a_msb;
    logic                      r_b_msb;
    logic [WIDTH-1:0]          r_result;
    logic                      r_c_out;
    logic                      r_ovf;
    logic                      r_zero;
    logic                      r_res_valid;

    logic [NIBBLE_W-1:0]       w_sum;
    logic                      w_p;
    logic                      w_g;
    logic                      w_cout;
    logic [WIDTH-1:0]          w_full;
    logic                      w_last;

    cla_seq_alu_ctrl_cla4 u_slice (
        .in1  (r_a[NIBBLE_W-1:0]),
        .in2  (r_b[NIBBLE_W-1:0]),
        .c_in (r_carry),
        .sum  (w_sum),
        .p    (w_p),
        .g    (w_g)
    );

    assign w_cout = w_g | (w_p & r_carry);
    // New nibble enters at the top; on the last RUN edge this is the full result.
    assign w_full = {w_sum, r_sh};
    assign w_last = (r_idx == IDX_W'(NIB - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sh        <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_result    <= '0;
            r_c_out     <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_a     <= op_a;
                        r_b     <= (sub == OP_SUB) ? ~op_b : op_b;
                        r_carry <= (sub == OP_SUB);
                        r_idx   <= '0;
                        r_a_msb <= op_a[WIDTH-1];
                        r_b_msb <= (sub == OP_SUB) ? ~op_b[WIDTH-1] : op_b[WIDTH-1];
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= {{NIBBLE_W{1'b0}}, r_a[WIDTH-1:NIBBLE_W]};
                    r_b     <= {{NIBBLE_W{1'b0}}, r_b[WIDTH-1:NIBBLE_W]};
                    r_sh    <= w_full[WIDTH-1:NIBBLE_W];
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_result    <= w_full;
                        r_c_out     <= w_cout;
                        r_ovf       <= (r_a_msb == r_b_msb) && (w_full[WIDTH-1] != r_a_msb);
                        r_zero      <= (w_full == '0);
                        r_res_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign start_ready = (r_state == IDLE);
    assign busy        = (r_state == RUN) || (r_state == DONE);
    assign res_valid   = r_res_valid;
    assign result      = r_result;
    assign c_out       = r_c_out;
    assign ovf         = r_ovf;
    assign zero        = r_zero;

endmodule : cla_seq_alu_ctrl
`default_nettype wire
